// File: rtl/dataloop_pkg.sv
// Shared types for the pipelined ALU data loop: opcode encoding and result flags.
// No logic here; imported by the interface, ALU and top.
// No handshake; pure type definitions.
package dataloop_pkg;

    typedef enum logic [2:0] {
        ADD   = 3'd0,
        SUB   = 3'd1,
        AND   = 3'd2,
        OR    = 3'd3,
        XOR   = 3'd4,
        PASSB = 3'd5,
        SHL   = 3'd6,
        SHR   = 3'd7
    } alu_op_e;

    typedef struct packed {
        logic cout;
        logic zero;
        logic ovf;
    } flags_t;

endpackage

// File: rtl/pipelined_dataloop_if.sv
// Instruction-issue, result and debug bundle of the pipelined data loop.
// No latency of its own; carries the in_valid/in_ready handshake.
// Backpressure: master must hold the instruction while in_ready is low.
interface pipelined_dataloop_if #(
    parameter int BitWidth     = 8,
    parameter int RegAddrWidth = 4
);
    import dataloop_pkg::*;

    logic                    in_valid;
    logic                    in_ready;
    alu_op_e                 in_op;
    logic [RegAddrWidth-1:0] in_a_addr;
    logic [RegAddrWidth-1:0] in_b_addr;
    logic [RegAddrWidth-1:0] in_c_addr;
    logic                    in_wr_en;
    logic                    in_imm_en;
    logic [BitWidth-1:0]     in_imm;

    logic                    res_valid;
    logic [BitWidth-1:0]     res_data;
    logic [RegAddrWidth-1:0] res_addr;
    logic                    res_wr;
    logic                    res_cout;
    logic                    res_zero;
    logic                    res_ovf;
    logic                    hazard_stall;

    logic [RegAddrWidth-1:0] dbg_addr;
    logic [BitWidth-1:0]     dbg_data;

    modport master (
        output in_valid, in_op, in_a_addr, in_b_addr, in_c_addr, in_wr_en, in_imm_en, in_imm, dbg_addr,
        input  in_ready, res_valid, res_data, res_addr, res_wr, res_cout, res_zero, res_ovf,
               hazard_stall, dbg_data
    );

    modport slave (
        input  in_valid, in_op, in_a_addr, in_b_addr, in_c_addr, in_wr_en, in_imm_en, in_imm, dbg_addr,
        output in_ready, res_valid, res_data, res_addr, res_wr, res_cout, res_zero, res_ovf,
               hazard_stall, dbg_data
    );

endinterface

// File: rtl/dataloop_alu.sv
// Combinational ALU: add/sub with carry and signed overflow, logic ops, pass-B, shifts.
// Latency: 0 cycles (pure combinational).
// No handshake; used by the EX stage and by the EX->ID forward path.
module dataloop_alu
    import dataloop_pkg::*;
#(
    parameter int BitWidth = 8
) (
    input  alu_op_e             i_op,
    input  logic [BitWidth-1:0] i_a,
    input  logic [BitWidth-1:0] i_b,
    output logic [BitWidth-1:0] o_res,
    output flags_t              o_flags
);
    localparam int ShiftWidth = $clog2(BitWidth);

    logic                  w_cin;
    logic [BitWidth-1:0]   w_b_add;
    logic [BitWidth:0]     w_sum;
    logic [ShiftWidth-1:0] w_shamt;

    // Subtraction reuses the adder as A + ~B + 1, so cout=1 means no borrow.
    assign w_cin   = (i_op == SUB);
    assign w_b_add = w_cin ? ~i_b : i_b;
    assign w_sum   = {1'b0, i_a} + {1'b0, w_b_add} + {{BitWidth{1'b0}}, w_cin};
    assign w_shamt = i_b[ShiftWidth-1:0];

    // Operation select; carry/overflow only meaningful for the adder ops.
    always_comb begin
        o_res   = '0;
        o_flags = '0;
        case (i_op)
            ADD, SUB: begin
                o_res        = w_sum[BitWidth-1:0];
                o_flags.cout = w_sum[BitWidth];
                o_flags.ovf  = (i_a[BitWidth-1] == w_b_add[BitWidth-1]) &&
                               (w_sum[BitWidth-1] != i_a[BitWidth-1]);
            end
            AND:     o_res = i_a & i_b;
            OR:      o_res = i_a | i_b;
            XOR:     o_res = i_a ^ i_b;
            PASSB:   o_res = i_b;
            SHL:     o_res = i_a << w_shamt;
            SHR:     o_res = i_a >> w_shamt;
            default: o_res = '0;
        endcase
        o_flags.zero = (o_res == '0);
    end

endmodule

// File: rtl/pipelined_dataloop.sv
// Three-stage (ID/EX/WB) ALU loop with 2R1W register file; DATALOOP_FORWARD_EN selects EX forwarding over stall.
// Latency: 2 cycles accept->res_valid, 1 instruction/cycle; WB result written through to ID reads.
// Backpressure: in_ready low when clk_en=0, in reset, or (no forwarding) for one cycle on an EX dependency.
module pipelined_dataloop
    import dataloop_pkg::*;
#(
    parameter int BitWidth      = 8,
    parameter int RegisterCount = 16,
    parameter int ZRenabled     = 0
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 clk_en,
    pipelined_dataloop_if.slave  bus
);
    localparam int RegAddrWidth = $clog2(RegisterCount);

    typedef logic [BitWidth-1:0]     data_t;
    typedef logic [RegAddrWidth-1:0] addr_t;

    data_t   r_regs [RegisterCount];

    logic    r_ex_vld;
    logic    r_ex_wr;
    alu_op_e r_ex_op;
    data_t   r_ex_a;
    data_t   r_ex_b;
    addr_t   r_ex_c;

    logic    r_wb_vld;
    logic    r_wb_wr;
    data_t   r_wb_data;
    addr_t   r_wb_addr;
    flags_t  r_wb_flags;

    data_t   w_alu_res;
    flags_t  w_alu_flags;
    logic    w_res_wr;
    logic    w_accept;
    logic    w_stall;
    data_t   w_b_dat;
    addr_t   w_src [2];
    data_t   w_rd  [2];
    logic    w_ex_hit [2];

    dataloop_alu #(.BitWidth(BitWidth)) u_alu (
        .i_op    (r_ex_op),
        .i_a     (r_ex_a),
        .i_b     (r_ex_b),
        .o_res   (w_alu_res),
        .o_flags (w_alu_flags)
    );

    assign w_src[0] = bus.in_a_addr;
    assign w_src[1] = bus.in_b_addr;
    assign w_res_wr = r_wb_vld & r_wb_wr & ~((ZRenabled != 0) && (r_wb_addr == '0));

    // Operand read: regfile, overridden by WB write-through, then EX forward, then the zero register.
    always_comb begin
        for (int p = 0; p < 2; p++) begin
            w_ex_hit[p] = r_ex_vld & r_ex_wr & (r_ex_c == w_src[p]) &
                          ~((ZRenabled != 0) && (w_src[p] == '0));
            w_rd[p] = r_regs[w_src[p]];
            if (w_res_wr && (r_wb_addr == w_src[p])) w_rd[p] = r_wb_data;
`ifdef DATALOOP_FORWARD_EN
            if (w_ex_hit[p]) w_rd[p] = w_alu_res;
`endif
            if ((ZRenabled != 0) && (w_src[p] == '0)) w_rd[p] = '0;
        end
    end

    assign w_b_dat = bus.in_imm_en ? bus.in_imm : w_rd[1];

`ifdef DATALOOP_FORWARD_EN
    assign w_stall = 1'b0;
`else
    assign w_stall = bus.in_valid & clk_en & rst_n &
                     (w_ex_hit[0] | (w_ex_hit[1] & ~bus.in_imm_en));
`endif

    assign bus.in_ready     = clk_en & rst_n & ~w_stall;
    assign bus.hazard_stall = w_stall;
    assign w_accept         = bus.in_valid & bus.in_ready;

    assign bus.res_valid = r_wb_vld;
    assign bus.res_data  = r_wb_data;
    assign bus.res_addr  = r_wb_addr;
    assign bus.res_wr    = w_res_wr;
    assign bus.res_cout  = r_wb_flags.cout;
    assign bus.res_zero  = r_wb_flags.zero;
    assign bus.res_ovf   = r_wb_flags.ovf;
    assign bus.dbg_data  = ((ZRenabled != 0) && (bus.dbg_addr == '0)) ? '0 : r_regs[bus.dbg_addr];

    // ID->EX: latch operands; a stall or idle cycle injects a bubble.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_ex_vld <= 1'b0;
            r_ex_wr  <= 1'b0;
            r_ex_op  <= ADD;
            r_ex_a   <= '0;
            r_ex_b   <= '0;
            r_ex_c   <= '0;
        end else if (clk_en) begin
            r_ex_vld <= w_accept;
            r_ex_wr  <= bus.in_wr_en;
            r_ex_op  <= bus.in_op;
            r_ex_a   <= w_rd[0];
            r_ex_b   <= w_b_dat;
            r_ex_c   <= bus.in_c_addr;
        end
    end

    // EX->WB: register ALU result and flags.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_wb_vld   <= 1'b0;
            r_wb_wr    <= 1'b0;
            r_wb_data  <= '0;
            r_wb_addr  <= '0;
            r_wb_flags <= '0;
        end else if (clk_en) begin
            r_wb_vld   <= r_ex_vld;
            r_wb_wr    <= r_ex_wr;
            r_wb_data  <= w_alu_res;
            r_wb_addr  <= r_ex_c;
            r_wb_flags <= w_alu_flags;
        end
    end

    // Register file: cleared by reset, written from WB.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < RegisterCount; i++) r_regs[i] <= '0;
        end else if (clk_en && w_res_wr) begin
            r_regs[r_wb_addr] <= r_wb_data;
        end
    end

endmodule

// File: doc/pipelined_dataloop.md
Name: pipelined_dataloop

Overview:
Three-stage pipelined ALU data loop (ID, EX, WB) with an internal register file, two read ports and one write port. It accepts one instruction per cycle through a valid/ready handshake and produces registered results and flags. Read-after-write hazards are resolved by write-through plus either an EX operand forwarder or a one-cycle issue stall. It succeeds the unpipelined dual-read RCA data loop and is the datapath core for the small OR-style CPU snippets.

Parameters:
BitWidth, 8, data width (>=4)
RegisterCount, 16, number of registers (power of 2, >=2)
ZRenabled, 0, 1 = register 0 reads as constant zero and ignores writes
RegAddrWidth, $clog2(RegisterCount), localparam
ShiftWidth, $clog2(BitWidth), localparam

Ports:
clk  in  1  clock
rst_n  in  1  synchronous active-low reset
clk_en  in  1  global advance; 0 freezes all state
in_valid  in  1  instruction present
in_ready  out  1  instruction accepted when in_valid & in_ready
in_op  in  3  alu_op_e
in_a_addr  in  RegAddrWidth  source A
in_b_addr  in  RegAddrWidth  source B (ignored if in_imm_en)
in_c_addr  in  RegAddrWidth  destination
in_wr_en  in  1  write result to in_c_addr
in_imm_en  in  1  B operand = in_imm
in_imm  in  BitWidth  immediate
res_valid  out  1  WB stage holds a result
res_data  out  BitWidth  result
res_addr  out  RegAddrWidth  destination of result
res_wr  out  1  result is being written to the register file
res_cout  out  1  carry out
res_zero  out  1  res_data == 0
res_ovf  out  1  signed overflow
hazard_stall  out  1  in_ready held low by the hazard detector this cycle
dbg_addr  in  RegAddrWidth  debug read address
dbg_data  out  BitWidth  combinational register-file read (post-ZR rule)

Behaviour:
- Reset: synchronous on rst_n=0 at a clk edge, and it overrides clk_en. After reset all registers are 0, EX/WB valid bits are 0, and res_* are all 0. in_ready=0 while rst_n=0. In-flight instructions are dropped with no register write.
- ID, cycle t (accept): operands are read combinationally and latched into EX at the edge ending t.
- EX, cycle t+1: the ALU computes. Result and flags are latched into WB at the edge ending t+1.
- WB, cycle t+2: res_* are valid. The register file is written at the edge ending t+2 when res_wr=1.
- Latency: 2 cycles from acceptance to res_valid. Throughput: 1 instruction per cycle.
- Write-through: when ID reads an address that WB is writing in the same cycle, ID gets the new value (covers dependency distance 2).
- res_wr = WB.valid & WB.wr_en & !(ZRenabled & res_addr==0).
- Operations:
  - ADD: A+B.
  - SUB: A+~B+1.
  - AND, OR, XOR.
  - PASSB: B.
  - SHL: A<<B[ShiftWidth-1:0], zero fill.
  - SHR: logical right shift, same amount rule.
- Flags:
  - res_cout = carry out of the adder for ADD/SUB (SUB: 1 = no borrow).
  - res_ovf = two's-complement overflow for ADD/SUB.
  - Both flags are 0 for every other op. res_zero applies to all ops.
- Dependency distance 1 (ID source equals EX dest with EX.valid & EX.wr_en): handling depends on DATALOOP_FORWARD_EN; see below. A source of r0 with ZRenabled never creates a hazard.
- clk_en=0: no state changes, in_ready=0, outputs hold their values.
- When a bubble enters EX (no accept, or a stall), the EX valid bit is 0. A bubble never writes the register file.

Optional Feature:
DATALOOP_FORWARD_EN.
- Defined: the ID source mux takes the EX ALU result combinationally on a distance-1 match. hazard_stall is tied to 0, and in_ready=clk_en & rst_n.
- Undefined: a distance-1 match drives in_ready=0 and hazard_stall=1 for exactly one cycle, and a bubble enters EX. The next cycle the match is resolved by write-through.

Decomposition:
- Package dataloop_pkg holds:
  - typedef enum logic [2:0] alu_op_e: ADD=0, SUB=1, AND=2, OR=3, XOR=4, PASSB=5, SHL=6, SHR=7.
  - A flags struct {cout, zero, ovf}.
- Sub-module dataloop_alu is purely combinational: op, a, b in; result and flags out. It is shared by the forward path.
- Register file, hazard and forward logic live inline.

Test Plan:
- Reset: hold rst_n=0 with clk_en=1 for 2 cycles. Expect res_valid=0, and dbg_data=0 for all addresses after release.
- Back-to-back dependency: ADD r1=r0+imm 5, then ADD r2=r1+r1 next cycle. Expect r2 result 10 (0x0A).
  - With FWD_EN: in_ready stays 1 and results come on consecutive cycles.
  - Without: one hazard_stall pulse, and the second result arrives 1 cycle later.
- Overflow: r1=0x80, r2=0x01, SUB r3=r1-r2. Expect res_data=0x7F, res_ovf=1, res_cout=1, res_zero=0.
- Zero register: ZRenabled=1, PASSB r0=imm 0x55. Expect res_valid=1, res_wr=0, dbg r0=0. Then ADD r4=r0+imm 3 gives 3 with no stall.
- Distance-2 plus freeze: SHL r5=imm 1 via r0, then an unrelated instruction, then SHR r6=r5>>imm 0. Drop clk_en for 3 cycles mid-flight; the pipeline holds, then completes with r6 = the r5 value.
- Reset mid-flight: assert rst_n=0 with 2 instructions in EX/WB. Expect no register-file writes and res_valid=0 on the next cycle.
